// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, opcode values and request FSM type for the fetch stage
package fetch_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LB = 6'h20;
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J = 6'h02;
  typedef enum logic {IDLE, REQ} req_state_e;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: instruction buffer of {pcplus4,instr} entries with push/pop/clear
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [63:0]              din,
  output logic [63:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  logic [63:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  // storage needs no reset; pointers decide what is live
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= din;
  end
  // pointers and occupancy; clear discards everything held
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= push ? r_wp + 1'b1 : r_wp;
      r_rp <= pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout = r_mem[r_rp];
  assign full = r_cnt == DEPTH_C;
  assign empty = r_cnt == '0;
  assign count = r_cnt;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem requests, instruction FIFO and IF/ID register; FETCH_PERF_EN adds perf counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pcplus4
`ifdef FETCH_PERF_EN
  ,output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  req_state_e r_state, w_state_nxt;
  logic [31:0] r_pc, r_addr, w_pc_nxt;
  logic r_drop;
  logic w_take, w_word, w_bypass, w_pop, w_push, w_full, w_empty;
  logic [CW-1:0] w_cnt, w_cnt_nxt;
  logic [63:0] w_head;
  assign imem_req = r_state == REQ;
  assign imem_addr = r_addr;
  // handshake decode, FIFO traffic, next PC and next request state
  always_comb begin
    w_take = imem_ack && r_state == REQ;
    w_word = w_take && !r_drop && !redirect;
    w_bypass = w_word && w_empty && !stall && !flush;
    w_pop = !redirect && !flush && !stall && !w_empty;
    w_push = w_word && !w_bypass;
    w_cnt_nxt = redirect ? '0 : w_cnt + CW'(w_push) - CW'(w_pop);
    w_pc_nxt = redirect ? {redirect_pc[31:2], 2'b00} : (w_take && !r_drop) ? r_pc + 32'd4 : r_pc;
    w_state_nxt = r_state == IDLE ? (w_cnt < DEPTH_C ? REQ : IDLE)
                : (w_take && w_cnt_nxt >= DEPTH_C) ? IDLE : REQ;
  end
  // request state register
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_state_nxt;
  end
  // PC, the address held on the bus, and the discard-next-word flag after a redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_addr <= RESET_PC;
      r_drop <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      r_addr <= (r_state == IDLE || w_take) ? w_pc_nxt : r_addr;
      r_drop <= (redirect && r_state == REQ && !imem_ack) ? 1'b1 : w_take ? 1'b0 : r_drop;
    end
  end
  // IF/ID register: squash, hold, pop from FIFO, bypass the returning word, or bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pcplus4 <= 32'd0;
    end else if (flush || redirect) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (!stall) begin
      id_valid <= !w_empty || w_bypass;
      id_instr <= !w_empty ? w_head[31:0] : w_bypass ? imem_rdata : NOP_INSTR;
      id_pcplus4 <= !w_empty ? w_head[63:32] : w_bypass ? r_addr + 32'd4 : id_pcplus4;
    end
  end
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({r_addr + 32'd4, imem_rdata}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );
`ifdef FETCH_PERF_EN
  logic [31:0] w_sq_amt;
  assign w_sq_amt = redirect ? 32'(id_valid) + 32'(w_cnt) : flush ? 32'(id_valid) : 32'd0;
  // saturating counts of delivered fetches and of valid words thrown away
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_squashed <= 32'd0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, 32'(w_word));
      perf_squashed <= sat_add(perf_squashed, w_sq_amt);
    end
  end
`endif
endmodule
